// File: rtl/conv_transpose_pkg.sv
// Shared types, widths and saturation helper for the transposed 1-D convolution layer.
package conv_transpose_pkg;

  localparam int DATA_W  = 16;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [31:0] v);
    if (v > SAT_MAX)      return DATA_W'(SAT_MAX);
    else if (v < SAT_MIN) return DATA_W'(SAT_MIN);
    else                  return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/conv_transpose_1d_f_rom.sv
// Filter coefficient ROM, 3-bit address, one cycle read latency.
module conv_transpose_1d_f_rom
  import conv_transpose_pkg::*;
(
  input  logic                     clk,
  input  logic [2:0]               addr,
  output logic signed [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    case (addr)
      3'd0:    data <= -16'sd245;
      3'd1:    data <= -16'sd12;
      3'd2:    data <= -16'sd57;
      3'd3:    data <= -16'sd210;
      3'd4:    data <= 16'sd153;
      3'd5:    data <= -16'sd250;
      default: data <= '0;
    endcase
  end

endmodule

// File: rtl/sp_mem.sv
// Generic single-port synchronous memory: write-enable port, registered read data.
module sp_mem #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 16
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [$clog2(SIZE)-1:0] addr,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/conv_transpose_1d.sv
// Transposed stride-1 1-D convolution: load N samples, compute N+F-1 saturated ReLU outputs, drain.
module conv_transpose_1d
  import conv_transpose_pkg::*;
#(
  parameter int N = 11,
  parameter int F = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] x_data,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              y_valid,
  input  logic              y_ready
);

  localparam int L    = N + F - 1;
  localparam int XA_W = $clog2(N);
  localparam int YA_W = $clog2(L);

  state_t state, state_next;

  logic [XA_W-1:0] count, x_addr;
  logic [YA_W-1:0] n, idx, y_addr, nk;
  logic [2:0]      k;
  logic            issuing, rd_valid, rd_first, rd_last, done;
  logic            x_we, y_we;

  logic [DATA_W-1:0]        x_rd_raw, y_rd, y_wdata;
  logic signed [DATA_W-1:0] x_rd, f_rd, acc, acc_base, acc_next, prod_sat;
  logic signed [31:0]       prod;
  logic signed [DATA_W:0]   sum;

  function automatic logic [2:0] k_lo(input logic [YA_W-1:0] nn);
    return (nn > YA_W'(N - 1)) ? 3'(nn - YA_W'(N - 1)) : 3'd0;
  endfunction

  function automatic logic [2:0] k_hi(input logic [YA_W-1:0] nn);
    return (nn < YA_W'(F - 1)) ? 3'(nn) : 3'(F - 1);
  endfunction

  sp_mem #(.WIDTH(DATA_W), .SIZE(N)) u_x_mem (
    .clk(clk), .we(x_we), .addr(x_addr), .wdata(x_data), .rdata(x_rd_raw)
  );

  sp_mem #(.WIDTH(DATA_W), .SIZE(L)) u_y_mem (
    .clk(clk), .we(y_we), .addr(y_addr), .wdata(y_wdata), .rdata(y_rd)
  );

  conv_transpose_1d_f_rom u_f_rom (.clk(clk), .addr(k), .data(f_rd));

  assign x_rd = $signed(x_rd_raw);
  assign nk   = n - YA_W'(k);

  // One tap per cycle: product saturated first, then the 17-bit sum saturated back to 16.
  always_comb begin
    prod     = $signed({{16{x_rd[DATA_W-1]}}, x_rd}) * $signed({{16{f_rd[DATA_W-1]}}, f_rd});
    prod_sat = sat16(prod);
    acc_base = rd_first ? '0 : acc;
    sum      = {acc_base[DATA_W-1], acc_base} + {prod_sat[DATA_W-1], prod_sat};
    acc_next = sat16(32'(sum));
    y_wdata  = acc_next[DATA_W-1] ? '0 : acc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    x_ready    = 1'b0;
    y_valid    = 1'b0;
    y_data     = '0;
    x_we       = 1'b0;
    y_we       = 1'b0;
    x_addr     = XA_W'(nk);
    y_addr     = '0;
    case (state)
      LOAD: begin
        x_ready = 1'b1;
        x_addr  = count;
        x_we    = x_valid;
        if (x_valid && count == XA_W'(N - 1)) state_next = COMPUTE;
      end
      COMPUTE: begin
        // The cycle after the last write reads y[0] so it is presented on DRAIN entry.
        y_we = rd_valid && rd_last;
        if (y_we) y_addr = n;
        if (done) state_next = DRAIN;
      end
      DRAIN: begin
        y_valid = 1'b1;
        y_data  = y_rd;
        y_addr  = (y_ready && idx != YA_W'(L - 1)) ? idx + 1'b1 : idx;
        if (y_ready && idx == YA_W'(L - 1)) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      idx      <= '0;
      n        <= '0;
      k        <= '0;
      issuing  <= 1'b0;
      rd_valid <= 1'b0;
      rd_first <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
      acc      <= '0;
    end else begin
      case (state)
        LOAD: if (x_valid) begin
          if (count == XA_W'(N - 1)) begin
            count    <= '0;
            n        <= '0;
            k        <= '0;
            issuing  <= 1'b1;
            rd_valid <= 1'b0;
            done     <= 1'b0;
          end else begin
            count <= count + 1'b1;
          end
        end
        COMPUTE: begin
          rd_valid <= issuing;
          if (issuing) begin
            rd_first <= (k == k_lo(n));
            rd_last  <= (k == k_hi(n));
            if (k == k_hi(n)) issuing <= 1'b0;
            else              k <= k + 1'b1;
          end
          if (rd_valid) begin
            acc <= acc_next;
            if (rd_last) begin
              if (n == YA_W'(L - 1)) begin
                done <= 1'b1;
              end else begin
                n       <= n + 1'b1;
                k       <= k_lo(n + 1'b1);
                issuing <= 1'b1;
              end
            end
          end
        end
        DRAIN: if (y_ready) begin
          idx <= (idx == YA_W'(L - 1)) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_transpose_1d.sv
// Directed self-checking bench for conv_transpose_1d with hand-computed expected outputs.
module tb_conv_transpose_1d;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x_data;
  logic        x_valid;
  logic        x_ready;
  logic [15:0] y_data;
  logic        y_valid;
  logic        y_ready;

  int n_checks = 0;
  int n_errors = 0;

  conv_transpose_1d dut (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  int x_imp[11]   = '{-1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int x_const[11] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
  int x_sat[11]   = '{-32768, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int y_imp[16]   = '{245, 12, 57, 210, 0, 250, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int y_const[16] = '{245, 257, 314, 524, 371, 621, 621, 621, 621, 621, 621, 376, 364, 307, 97, 250};
  int y_sat[16]   = '{32767, 32767, 32767, 32767, 0, 32767, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_frame(input int v[11], input bit gappy);
    int i = 0;
    int guard = 0;
    while (i < 11 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (gappy && $urandom_range(0, 1) == 0) begin
        x_valid = 1'b0;
        x_data  = 16'($urandom);
      end else begin
        x_valid = 1'b1;
        x_data  = 16'(v[i]);
        if (x_ready) i++;
      end
    end
    check("x_accepted", i, 11);
    @(negedge clk);
    x_valid = 1'b0;
  endtask

  task automatic recv_frame(input int e[16], input bit bp, input bit noisy, input int stop_after);
    int j = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int first_lat = -1;
    bit prev_stall = 1'b0;
    logic [15:0] held = '0;
    while (j < stop_after && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (y_valid && first_lat < 0) first_lat = cyc;
      if (prev_stall) begin
        check("stall_valid", int'(y_valid), 1);
        check("stall_data", int'(y_data), int'(held));
      end
      if (noisy) begin
        x_valid = 1'($urandom_range(0, 1));
        x_data  = 16'($urandom);
      end
      if (bp) begin
        if (j == 8 && stall_cnt < 20) begin
          y_ready = 1'b0;
          stall_cnt++;
        end else begin
          y_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        y_ready = 1'b1;
      end
      prev_stall = y_valid && !y_ready;
      held = y_data;
      if (y_valid && y_ready) begin
        check($sformatf("y[%0d]", j), int'(y_data), e[j]);
        j++;
      end
    end
    check("words_seen", j, stop_after);
    check("first_valid_in_budget", int'(first_lat >= 1 && first_lat <= 130), 1);
    if (stop_after == 16) begin
      @(negedge clk);
      x_valid = 1'b0;
      y_ready = 1'b0;
      check("end_y_valid", int'(y_valid), 0);
      check("end_x_ready", int'(x_ready), 1);
    end
  endtask

  initial begin
    reset   = 1'b1;
    x_data  = '0;
    x_valid = 1'b0;
    y_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_x_ready", int'(x_ready), 1);
    check("rst_y_valid", int'(y_valid), 0);
    check("rst_y_data", int'(y_data), 0);

    send_frame(x_imp, 1'b0);
    recv_frame(y_imp, 1'b0, 1'b0, 16);

    send_frame(x_const, 1'b0);
    recv_frame(y_const, 1'b0, 1'b0, 16);

    send_frame(x_sat, 1'b0);
    recv_frame(y_sat, 1'b0, 1'b0, 16);

    send_frame(x_const, 1'b0);
    recv_frame(y_const, 1'b1, 1'b0, 16);

    send_frame(x_const, 1'b1);
    recv_frame(y_const, 1'b1, 1'b1, 16);

    send_frame(x_imp, 1'b0);
    recv_frame(y_imp, 1'b0, 1'b0, 5);
    @(negedge clk);
    reset   = 1'b1;
    y_ready = 1'b0;
    x_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_x_ready", int'(x_ready), 1);
    check("mid_rst_y_valid", int'(y_valid), 0);
    check("mid_rst_y_data", int'(y_data), 0);

    send_frame(x_imp, 1'b0);
    recv_frame(y_imp, 1'b0, 1'b0, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
